// File: rtl/img_loader.sv
// img_loader: front-end stage of the CNN accelerator.
// Accepts one IMG_W x IMG_H grayscale frame as a valid/ready pixel stream and writes it in
// raster order to port A of both image memory copies. It then pulses cnn_start and holds off
// further input until cnn_done, so the image stays stable during inference.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset_n    in   synchronous active-low reset
//   pix_valid  in   upstream pixel valid
//   pix_ready  out  loader can accept a pixel (LOAD state only)
//   pix_data   in   pixel value
//   pix_last   in   marks the final pixel of a frame
//   mem_addr   out  write address to both memory copies (registered)
//   mem_data   out  write data to both memory copies (registered)
//   mem_wren   out  write enable to both memory copies (registered)
//   cnn_start  out  one-cycle pulse: frame committed, start inference
//   cnn_done   in   one-cycle pulse: inference finished (ignored outside RUN)
//   frame_err  out  sticky framing-error flag
//   err_clr    in   clears frame_err; a simultaneous new error wins
//   busy       out  high while a frame is held for the CNN
module img_loader #(
   parameter int unsigned IMG_W  = 28,
   parameter int unsigned IMG_H  = 28,
   parameter int unsigned PIX_W  = 8,
   parameter int unsigned ADDR_W = 10
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              pix_valid,
   output logic              pix_ready,
   input  logic [PIX_W-1:0]  pix_data,
   input  logic              pix_last,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [PIX_W-1:0]  mem_data,
   output logic              mem_wren,
   output logic              cnn_start,
   input  logic              cnn_done,
   output logic              frame_err,
   input  logic              err_clr,
   output logic              busy
);

   localparam int unsigned       NumPix  = IMG_W * IMG_H;
   localparam logic [ADDR_W-1:0] LastIdx = ADDR_W'(NumPix - 1);

   typedef enum logic [1:0] {StLoad, StFire, StRun} state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] cnt_q, cnt_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [PIX_W-1:0]  data_q, data_d;
   logic              wren_q, wren_d;
   logic              start_q, start_d;
   logic              err_q, err_d;
   logic              err_set;
   logic              beat;

   assign pix_ready = (state_q == StLoad);
   assign busy      = (state_q != StLoad);
   assign beat      = pix_valid & pix_ready;

   assign mem_addr  = addr_q;
   assign mem_data  = data_q;
   assign mem_wren  = wren_q;
   assign cnn_start = start_q;
   assign frame_err = err_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      data_d  = data_q;
      wren_d  = 1'b0;
      // Registered so the pulse lands one cycle after FIRE, once the final write is committed.
      start_d = (state_q == StFire);
      err_set = 1'b0;

      unique case (state_q)
         StLoad: begin
            if (beat) begin
               addr_d = cnt_q;
               data_d = pix_data;
               wren_d = 1'b1;
               if (cnt_q == LastIdx) begin
                  // Full frame: used even if pix_last is missing, but flagged.
                  cnt_d   = '0;
                  state_d = StFire;
                  err_set = ~pix_last;
               end else if (pix_last) begin
                  // Early last: partial frame is simply overwritten by the next one.
                  cnt_d   = '0;
                  err_set = 1'b1;
               end else begin
                  cnt_d = cnt_q + 1'b1;
               end
            end
         end
         StFire: state_d = StRun;
         StRun: begin
            if (cnn_done) state_d = StLoad;
         end
         default: state_d = StLoad;
      endcase

      err_d = err_set | (err_q & ~err_clr);
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= StLoad;
         cnt_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         wren_q  <= 1'b0;
         start_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         wren_q  <= wren_d;
         start_q <= start_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_img_loader.sv
// Self-checking bench for img_loader. A negedge monitor records every memory write and
// cnn_start pulse; tasks compare those records against expectations built from the
// stimulus (pixel index -> address, source pixel -> data, frame rules -> start/err).
module tb_img_loader;

   localparam int IMG_W  = 28;
   localparam int IMG_H  = 28;
   localparam int PIX_W  = 8;
   localparam int ADDR_W = 10;
   localparam int N      = IMG_W * IMG_H;

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              pix_valid = 1'b0;
   logic              pix_ready;
   logic [PIX_W-1:0]  pix_data = '0;
   logic              pix_last = 1'b0;
   logic [ADDR_W-1:0] mem_addr;
   logic [PIX_W-1:0]  mem_data;
   logic              mem_wren;
   logic              cnn_start;
   logic              cnn_done = 1'b0;
   logic              frame_err;
   logic              err_clr = 1'b0;
   logic              busy;

   img_loader #(
      .IMG_W  (IMG_W),
      .IMG_H  (IMG_H),
      .PIX_W  (PIX_W),
      .ADDR_W (ADDR_W)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .pix_valid (pix_valid),
      .pix_ready (pix_ready),
      .pix_data  (pix_data),
      .pix_last  (pix_last),
      .mem_addr  (mem_addr),
      .mem_data  (mem_data),
      .mem_wren  (mem_wren),
      .cnn_start (cnn_start),
      .cnn_done  (cnn_done),
      .frame_err (frame_err),
      .err_clr   (err_clr),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int addr;
      int data;
      int c;
   } wr_t;

   wr_t  wr_q[$];
   int   exp_pix[$];
   int   start_cnt = 0;
   int   start_cyc = 0;
   int   last_cyc  = 0;
   int   done_cyc  = 0;
   int   total = 0;
   int   bad   = 0;
   logic [PIX_W-1:0] ram [0:(1<<ADDR_W)-1];

   // Bus monitor, sampled mid-cycle.
   always @(negedge clk) begin
      wr_t w;
      if (mem_wren === 1'b1) begin
         w.addr = int'(mem_addr);
         w.data = int'(mem_data);
         w.c    = cyc;
         wr_q.push_back(w);
         ram[mem_addr] = mem_data;
      end
      if (cnn_start === 1'b1) begin
         start_cnt++;
         start_cyc = cyc;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_logs();
      wr_q.delete();
      exp_pix.delete();
      start_cnt = 0;
   endtask

   // Streams n pixels; gap_pct is the chance of an idle cycle before each pixel.
   task automatic send_pixels(input int n, input int gap_pct, input bit with_last,
                              input bit ramp);
      for (int i = 0; i < n; i++) begin
         while (int'($urandom_range(99)) < gap_pct) begin
            pix_valid = 1'b0;
            pix_last  = 1'b0;
            tick();
         end
         pix_valid = 1'b1;
         pix_data  = ramp ? PIX_W'(exp_pix.size()) : PIX_W'($urandom);
         pix_last  = with_last && (i == n - 1);
         exp_pix.push_back(int'(pix_data));
         tick();
         last_cyc = cyc;
      end
      pix_valid = 1'b0;
      pix_last  = 1'b0;
   endtask

   task automatic release_cnn();
      cnn_done = 1'b1;
      tick();
      done_cyc = cyc;
      cnn_done = 1'b0;
   endtask

   // Number of logged writes in [first, first+cnt) whose address is not the pixel's raster
   // index (relative to first) or whose data differs from the source pixel.
   function automatic int seq_bad(input int first, input int cnt);
      int nb = 0;
      for (int i = 0; i < cnt; i++) begin
         if (first + i >= wr_q.size()) nb++;
         else if (wr_q[first+i].addr != i || wr_q[first+i].data != exp_pix[first+i]) nb++;
      end
      return nb;
   endfunction

   task automatic test_reset();
      reset_n = 1'b0;
      tick();
      total++; if (pix_ready !== 1'b1) begin bad++; $display("FAIL reset_ready: got %b want 1", pix_ready); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (mem_wren !== 1'b0) begin bad++; $display("FAIL reset_wren: got %b want 0", mem_wren); end
      total++; if (mem_addr !== '0) begin bad++; $display("FAIL reset_addr: got %0d want 0", mem_addr); end
      total++; if (mem_data !== '0) begin bad++; $display("FAIL reset_data: got %0d want 0", mem_data); end
      total++; if (cnn_start !== 1'b0) begin bad++; $display("FAIL reset_start: got %b want 0", cnn_start); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", frame_err); end
      reset_n = 1'b1;
   endtask

   task automatic test_full_frame();
      int nb;
      clear_logs();
      send_pixels(N, 0, 1'b1, 1'b1);
      repeat (3) tick();
      total++; if (wr_q.size() != N) begin bad++; $display("FAIL full_count: got %0d want %0d", wr_q.size(), N); end
      nb = seq_bad(0, N);
      total++; if (nb != 0) begin bad++; $display("FAIL full_seq: got %0d bad writes want 0", nb); end
      if (wr_q.size() == N) begin
         total++;
         if (wr_q[N-1].c - wr_q[0].c != N - 1) begin
            bad++; $display("FAIL full_b2b: got span %0d want %0d", wr_q[N-1].c - wr_q[0].c, N - 1);
         end
         total++;
         if (wr_q[N-1].c != last_cyc) begin
            bad++; $display("FAIL full_wr_lat: got %0d want %0d", wr_q[N-1].c, last_cyc);
         end
      end
      total++; if (start_cnt != 1) begin bad++; $display("FAIL full_start_cnt: got %0d want 1", start_cnt); end
      total++; if (start_cyc != last_cyc + 1) begin bad++; $display("FAIL full_start_cyc: got %0d want %0d", start_cyc, last_cyc + 1); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL full_err: got %b want 0", frame_err); end
      total++; if (pix_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL full_hold: got ready=%b busy=%b want 0 1", pix_ready, busy); end
      release_cnn();
      total++; if (pix_ready !== 1'b1 || busy !== 1'b0) begin bad++; $display("FAIL full_resume: got ready=%b busy=%b want 1 0", pix_ready, busy); end
   endtask

   task automatic test_random_gaps();
      int nb;
      int rb = 0;
      clear_logs();
      send_pixels(N, 50, 1'b1, 1'b0);
      repeat (3) tick();
      total++; if (wr_q.size() != N) begin bad++; $display("FAIL gap_count: got %0d want %0d", wr_q.size(), N); end
      nb = seq_bad(0, N);
      total++; if (nb != 0) begin bad++; $display("FAIL gap_seq: got %0d bad writes want 0", nb); end
      for (int i = 0; i < N; i++) if (int'(ram[i]) != exp_pix[i]) rb++;
      total++; if (rb != 0) begin bad++; $display("FAIL gap_ram: got %0d bad words want 0", rb); end
      total++; if (start_cnt != 1) begin bad++; $display("FAIL gap_start_cnt: got %0d want 1", start_cnt); end
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL gap_err: got %b want 0", frame_err); end
      release_cnn();
   endtask

   task automatic test_early_last();
      int nb;
      clear_logs();
      send_pixels(100, 20, 1'b1, 1'b0);
      repeat (3) tick();
      total++; if (wr_q.size() != 100) begin bad++; $display("FAIL early_count: got %0d want 100", wr_q.size()); end
      total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL early_err: got %b want 1", frame_err); end
      total++; if (start_cnt != 0) begin bad++; $display("FAIL early_start: got %0d want 0", start_cnt); end
      total++; if (pix_ready !== 1'b1) begin bad++; $display("FAIL early_ready: got %b want 1", pix_ready); end
      clear_logs();
      send_pixels(N, 10, 1'b1, 1'b0);
      repeat (3) tick();
      nb = seq_bad(0, N);
      total++; if (nb != 0 || wr_q.size() != N) begin bad++; $display("FAIL early_next_seq: got %0d bad of %0d want 0 of %0d", nb, wr_q.size(), N); end
      total++; if (start_cnt != 1) begin bad++; $display("FAIL early_next_start: got %0d want 1", start_cnt); end
      release_cnn();
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL early_clr: got %b want 0", frame_err); end
   endtask

   task automatic test_missing_last();
      clear_logs();
      send_pixels(N, 0, 1'b0, 1'b0);
      repeat (3) tick();
      total++; if (start_cnt != 1) begin bad++; $display("FAIL nolast_start: got %0d want 1", start_cnt); end
      total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL nolast_err: got %b want 1", frame_err); end
      release_cnn();
      err_clr = 1'b1;
      tick();
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL nolast_clr: got %b want 0", frame_err); end
      // A one-pixel frame with pix_last is an early-last error, coinciding with err_clr.
      clear_logs();
      send_pixels(1, 0, 1'b1, 1'b0);
      err_clr = 1'b0;
      total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL set_wins: got %b want 1", frame_err); end
      err_clr = 1'b1;
      tick();
      err_clr = 1'b0;
      total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL set_wins_clr: got %b want 0", frame_err); end
   endtask

   task automatic test_run_block();
      int nb;
      clear_logs();
      send_pixels(500, 0, 1'b0, 1'b1);
      cnn_done = 1'b1;
      tick();
      cnn_done = 1'b0;
      send_pixels(N - 500, 0, 1'b1, 1'b1);
      pix_valid = 1'b1;
      pix_data  = 8'hA5;
      repeat (10) tick();
      total++; if (wr_q.size() != N) begin bad++; $display("FAIL run_nowrite: got %0d writes want %0d", wr_q.size(), N); end
      total++; if (start_cnt != 1) begin bad++; $display("FAIL run_start: got %0d want 1", start_cnt); end
      total++; if (busy !== 1'b1 || pix_ready !== 1'b0) begin bad++; $display("FAIL run_hold: got busy=%b ready=%b want 1 0", busy, pix_ready); end
      release_cnn();
      total++; if (pix_ready !== 1'b1) begin bad++; $display("FAIL run_resume: got %b want 1", pix_ready); end
      repeat (3) tick();
      pix_valid = 1'b0;
      repeat (2) tick();
      nb = seq_bad(0, N);
      total++; if (nb != 0) begin bad++; $display("FAIL run_seq: got %0d bad writes want 0", nb); end
      total++; if (wr_q.size() != N + 3) begin bad++; $display("FAIL run_resume_cnt: got %0d want %0d", wr_q.size(), N + 3); end
      if (wr_q.size() >= N + 2) begin
         total++;
         if (wr_q[N].addr != 0 || wr_q[N+1].addr != 1 || wr_q[N].data != 'hA5) begin
            bad++; $display("FAIL run_resume_addr: got %0d,%0d data %0d want 0,1 data 165",
                            wr_q[N].addr, wr_q[N+1].addr, wr_q[N].data);
         end
         total++;
         if (wr_q[N].c != done_cyc + 1) begin
            bad++; $display("FAIL run_resume_cyc: got %0d want %0d", wr_q[N].c, done_cyc + 1);
         end
      end
   endtask

   task automatic test_mid_reset();
      int nb;
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      clear_logs();
      send_pixels(399, 0, 1'b0, 1'b0);
      pix_valid = 1'b1;
      pix_data  = 8'h3C;
      reset_n   = 1'b0;
      tick();
      reset_n   = 1'b1;
      pix_valid = 1'b0;
      total++; if (mem_wren !== 1'b0 || mem_addr !== '0 || mem_data !== '0) begin
         bad++; $display("FAIL mid_rst_bus: got wren=%b addr=%0d data=%0d want 0 0 0", mem_wren, mem_addr, mem_data);
      end
      total++; if (pix_ready !== 1'b1 || busy !== 1'b0 || cnn_start !== 1'b0 || frame_err !== 1'b0) begin
         bad++; $display("FAIL mid_rst_ctl: got ready=%b busy=%b start=%b err=%b want 1 0 0 0",
                         pix_ready, busy, cnn_start, frame_err);
      end
      clear_logs();
      send_pixels(N, 25, 1'b1, 1'b0);
      repeat (3) tick();
      nb = seq_bad(0, N);
      total++; if (nb != 0 || wr_q.size() != N) begin bad++; $display("FAIL mid_rst_seq: got %0d bad of %0d want 0 of %0d", nb, wr_q.size(), N); end
      total++; if (start_cnt != 1 || frame_err !== 1'b0) begin bad++; $display("FAIL mid_rst_fire: got start=%0d err=%b want 1 0", start_cnt, frame_err); end
      release_cnn();
   endtask

   initial begin
      test_reset();
      test_full_frame();
      test_random_gaps();
      test_early_last();
      test_missing_last();
      test_run_block();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
